// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority arbiter sharing the byte-wide memory port
// between NUM_PORTS requesters (0 = wasm loader, 1 = cpu, 2 = debug/bench).
// Lowest port index wins. Each access runs IDLE -> BUSY -> GAP, so the
// memory always sees a deasserted enable between two accesses.
// All outputs are driven from registers.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a BUSY phase after
// TIMEOUT_CYCLES without mem_ready. An aborted access still gets its ack,
// returns 8'hFF and sets the sticky err flag.
module mem_arbiter #(
   parameter int NUM_PORTS      = 3,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*8-1:0]        wdata,
   output logic [NUM_PORTS-1:0]          ack,
   output logic [7:0]                    rdata,
   output logic [NUM_PORTS-1:0]          grant,
   output logic                          err,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [7:0]                    mem_data_in,
   output logic                          mem_read_en,
   output logic                          mem_write_en,
   input  logic [7:0]                    mem_data_out,
   input  logic                          mem_ready
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   state_t                  state_r;
   logic                    hit_s;
   logic [NUM_PORTS-1:0]    win_oh_s;
   logic [ADDR_W-1:0]       win_addr_s;
   logic [7:0]              win_wdata_s;
   logic                    win_we_s;

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]        tmo_cnt_r;
`endif

   // Fixed-priority pick: the lowest requesting index and its address/data/we.
   always_comb begin
      hit_s       = 1'b0;
      win_oh_s    = '0;
      win_addr_s  = '0;
      win_wdata_s = 8'h00;
      win_we_s    = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (req[i] && !hit_s) begin
            hit_s       = 1'b1;
            win_oh_s[i] = 1'b1;
            win_addr_s  = addr[i*ADDR_W +: ADDR_W];
            win_wdata_s = wdata[i*8 +: 8];
            win_we_s    = we[i];
         end else begin
            win_oh_s[i] = 1'b0;
         end
      end
   end

   // Transaction sequencer: grant, drive memory from registers, ack, gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         ack          <= '0;
         grant        <= '0;
         rdata        <= 8'h00;
         err          <= 1'b0;
         mem_addr     <= '0;
         mem_data_in  <= 8'h00;
         mem_read_en  <= 1'b0;
         mem_write_en <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
         tmo_cnt_r    <= '0;
`endif
      end else begin
         ack <= '0;
         case (state_r)
            ST_IDLE: begin
               if (hit_s) begin
                  grant        <= win_oh_s;
                  mem_addr     <= win_addr_s;
                  mem_data_in  <= win_wdata_s;
                  mem_write_en <= win_we_s;
                  mem_read_en  <= ~win_we_s;
`ifdef MEM_ARB_TIMEOUT_EN
                  tmo_cnt_r    <= '0;
`endif
                  state_r      <= ST_BUSY;
               end else begin
                  state_r      <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (mem_ready) begin
                  if (mem_read_en) begin
                     rdata <= mem_data_out;
                  end else begin
                     rdata <= rdata;
                  end
                  ack          <= grant;
                  grant        <= '0;
                  mem_read_en  <= 1'b0;
                  mem_write_en <= 1'b0;
                  state_r      <= ST_GAP;
               end
`ifdef MEM_ARB_TIMEOUT_EN
               else if (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  // Memory never answered: complete the access with a poison byte.
                  rdata        <= 8'hFF;
                  err          <= 1'b1;
                  ack          <= grant;
                  grant        <= '0;
                  mem_read_en  <= 1'b0;
                  mem_write_en <= 1'b0;
                  state_r      <= ST_GAP;
               end else begin
                  tmo_cnt_r    <= tmo_cnt_r + CNT_W'(1);
                  state_r      <= ST_BUSY;
               end
`else
               else begin
                  state_r      <= ST_BUSY;
               end
`endif
            end
            ST_GAP: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a byte-array memory
// responder of programmable latency. Expected values are hand-computed.
module tb_mem_arbiter;

   localparam int NP = 3;
   localparam int AW = 32;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NP-1:0]     req = '0;
   logic [NP-1:0]     we = '0;
   logic [NP*AW-1:0]  addr = '0;
   logic [NP*8-1:0]   wdata = '0;
   logic [NP-1:0]     ack;
   logic [7:0]        rdata;
   logic [NP-1:0]     grant;
   logic              err;
   logic [AW-1:0]     mem_addr;
   logic [7:0]        mem_data_in;
   logic              mem_read_en;
   logic              mem_write_en;
   logic [7:0]        mem_data_out = 8'h00;
   logic              mem_ready = 1'b0;

   int                total = 0;
   int                bad = 0;
   logic [7:0]        mem_arr [256];
   bit                mem_auto = 1'b1;
   int                lat = 0;
   int                wait_cnt = 0;
   int                ack_cnt [NP];
   bit                both_seen = 1'b0;

   mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .grant(grant), .err(err),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
      .mem_data_out(mem_data_out), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   // Memory responder: answers an enabled access after lat idle cycles.
   always @(negedge clk) begin
      if (mem_auto && (mem_read_en || mem_write_en) && !mem_ready) begin
         if (wait_cnt == lat) begin
            if (mem_write_en) mem_arr[mem_addr[7:0]] = mem_data_in;
            mem_data_out = mem_arr[mem_addr[7:0]];
            mem_ready = 1'b1;
            wait_cnt = 0;
         end else begin
            wait_cnt++;
         end
      end else begin
         mem_ready = 1'b0;
         if (!mem_auto) wait_cnt = 0;
      end
   end

   // Monitor: ack pulse counts per port and enable exclusivity.
   always begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NP; i++) ack_cnt[i] += int'(ack[i]);
      if (mem_read_en && mem_write_en) both_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_grant(input string tag, input logic [NP-1:0] exp);
      int n = 0;
      do begin step(); n++; end while (grant == '0 && n < 12);
      chk(tag, 64'(grant), 64'(exp));
   endtask

   task automatic wait_ack(input string tag, input int p);
      int n = 0;
      do begin step(); n++; end while (!ack[p] && n < 12);
      chk(tag, 64'(ack[p]), 64'd1);
   endtask

   initial begin
      int a0;
      int n;
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
      for (int i = 0; i < NP; i++) ack_cnt[i] = 0;
      mem_arr[8'h04] = 8'h08;
      mem_arr[8'h20] = 8'h11;
      mem_arr[8'h30] = 8'h22;

      // Reset state
      step(); step();
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_ack", 64'(ack), 64'd0);
      chk("rst_rdata", 64'(rdata), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_en", 64'({mem_read_en, mem_write_en}), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      rst = 1'b0;
      step();

      // 1. Single read by port 1
      addr[1*AW +: AW] = 32'h604;
      req = 3'b010;
      step();
      chk("t1_grant", 64'(grant), 64'h2);
      chk("t1_rden", 64'({mem_read_en, mem_write_en}), 64'h2);
      chk("t1_addr", 64'(mem_addr), 64'h604);
      chk("t1_noack", 64'(ack), 64'd0);
      step();
      chk("t1_ack", 64'(ack), 64'h2);
      chk("t1_rdata", 64'(rdata), 64'h08);
      chk("t1_gap_grant", 64'(grant), 64'd0);
      req = 3'b000;
      step();
      chk("t1_ack_once", 64'(ack), 64'd0);
      chk("t1_ackcnt", 64'(ack_cnt[1]), 64'd1);

      // 2. Port 2 writes A5 to 'h10, then reads it back
      addr[2*AW +: AW] = 32'h10;
      wdata[2*8 +: 8] = 8'hA5;
      we = 3'b100;
      req = 3'b100;
      step();
      chk("t2_wgrant", 64'(grant), 64'h4);
      chk("t2_wren", 64'({mem_read_en, mem_write_en}), 64'h1);
      chk("t2_wdata", 64'(mem_data_in), 64'hA5);
      step();
      chk("t2_wack", 64'(ack), 64'h4);
      chk("t2_rdata_kept", 64'(rdata), 64'h08);
      we = 3'b000;
      step();
      chk("t2_idle_grant", 64'(grant), 64'd0);
      step();
      chk("t2_rgrant", 64'(grant), 64'h4);
      chk("t2_rden", 64'({mem_read_en, mem_write_en}), 64'h2);
      step();
      chk("t2_rack", 64'(ack), 64'h4);
      chk("t2_rdata", 64'(rdata), 64'hA5);
      req = 3'b000;
      chk("t2_ackcnt", 64'(ack_cnt[2]), 64'd2);

      // 3. Contention: port 0 wins while it keeps requesting
      addr[0*AW +: AW] = 32'h20;
      addr[1*AW +: AW] = 32'h30;
      addr[2*AW +: AW] = 32'h40;
      req = 3'b111;
      for (int t = 0; t < 3; t++) begin
         wait_grant("t3_grant0", 3'b001);
         wait_ack("t3_ack0", 0);
         chk("t3_gap", 64'(grant), 64'd0);
         chk("t3_rdata0", 64'(rdata), 64'h11);
      end
      req = 3'b110;
      wait_grant("t3_grant1", 3'b010);
      wait_ack("t3_ack1", 1);
      chk("t3_rdata1", 64'(rdata), 64'h22);
      req = 3'b000;

      // 4. Port 1 drops req mid-BUSY with a slow memory
      lat = 3;
      a0 = ack_cnt[1];
      req = 3'b010;
      wait_grant("t4_grant", 3'b010);
      req = 3'b000;
      step();
      chk("t4_hold", 64'(grant), 64'h2);
      wait_ack("t4_ack", 1);
      chk("t4_rdata", 64'(rdata), 64'h22);
      repeat (4) step();
      chk("t4_no_regrant", 64'(grant), 64'd0);
      chk("t4_ackcnt", 64'(ack_cnt[1]), 64'(a0 + 1));
      lat = 0;

      // 5. Reset between grant and mem_ready
      mem_auto = 1'b0;
      a0 = ack_cnt[0];
      req = 3'b001;
      wait_grant("t5_grant", 3'b001);
      step();
      rst = 1'b1;
      #1;
      chk("t5_grant", 64'(grant), 64'd0);
      chk("t5_en", 64'({mem_read_en, mem_write_en}), 64'd0);
      chk("t5_addr", 64'(mem_addr), 64'd0);
      chk("t5_rdata", 64'(rdata), 64'd0);
      step();
      rst = 1'b0;
      mem_auto = 1'b1;
      wait_grant("t5_regrant", 3'b001);
      wait_ack("t5_ack", 0);
      chk("t5_rdata_after", 64'(rdata), 64'h11);
      chk("t5_ackcnt", 64'(ack_cnt[0]), 64'(a0 + 1));
      req = 3'b000;

      // 6. Memory never answers
      mem_auto = 1'b0;
      a0 = ack_cnt[1];
      req = 3'b010;
      wait_grant("t6_grant", 3'b010);
`ifdef MEM_ARB_TIMEOUT_EN
      n = 0;
      do begin step(); n++; end while (!ack[1] && n < 20);
      chk("t6_tmo_cycles", 64'(n), 64'd8);
      chk("t6_tmo_rdata", 64'(rdata), 64'hFF);
      chk("t6_tmo_err", 64'(err), 64'd1);
      req = 3'b000;
      mem_auto = 1'b1;
      repeat (5) step();
      chk("t6_err_sticky", 64'(err), 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t6_err_clr", 64'(err), 64'd0);
`else
      n = 0;
      repeat (100) begin step(); n++; end
      chk("t6_still_busy", 64'(grant), 64'h2);
      chk("t6_still_en", 64'(mem_read_en), 64'd1);
      chk("t6_err0", 64'(err), 64'd0);
      chk("t6_noack", 64'(ack_cnt[1]), 64'(a0));
      req = 3'b000;
      rst = 1'b1;
      step();
      rst = 1'b0;
      mem_auto = 1'b1;
`endif
      step();
      chk("both_en_never", 64'(both_seen), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
